// File: rtl/multi_word_adder_controller_pkg.sv
// Shared constants and types for the multi-word adder controller.
// The state encoding is fixed so other blocks can decode the state register.
package multi_word_adder_controller_pkg;

    localparam int bits = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multi_word_adder_controller_adder.sv
// The existing single-word ripple adder, reused once per word by the controller.
// Produces Sum = A + B + CarryIN with the carry out of the top bit.
module sixteen_bit_adder
    import multi_word_adder_controller_pkg::*;
(
    input  logic [bits-1:0] A,
    input  logic [bits-1:0] B,
    input  logic            CarryIN,
    output logic            CarryOUT,
    output logic [bits-1:0] Sum
);

    assign {CarryOUT, Sum} = {1'b0, A} + {1'b0, B} + {{bits{1'b0}}, CarryIN};

endmodule

// File: rtl/multi_word_adder_controller.sv
// Multi-precision add/subtract that streams WORDS words through one 16-bit adder,
// least-significant word first, with the carry held in a register between words.
module multi_word_adder_controller
    import multi_word_adder_controller_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  StartValid,
    output logic                  StartReady,
    input  logic [WORDS*bits-1:0] A,
    input  logic [WORDS*bits-1:0] B,
    input  logic                  CarryIN,
    input  logic                  Sub,
    output logic [WORDS*bits-1:0] Sum,
    output logic                  CarryOUT,
    output logic                  Overflow,
    output logic                  DoneValid,
    input  logic                  DoneReady
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t state, next_state;

    logic [WORDS*bits-1:0] a_q;
    logic [WORDS*bits-1:0] b_q;
    logic                  carry_q;
    logic [IDX_W-1:0]      idx;

    logic [bits-1:0] a_word;
    logic [bits-1:0] b_word;
    logic [bits-1:0] add_sum;
    logic            add_cout;
    logic            last_word;

    assign a_word    = a_q[idx*bits +: bits];
    assign b_word    = b_q[idx*bits +: bits];
    assign last_word = (idx == LAST_IDX);

    sixteen_bit_adder u_adder (
        .A        (a_word),
        .B        (b_word),
        .CarryIN  (carry_q),
        .CarryOUT (add_cout),
        .Sum      (add_sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (StartValid) next_state = RUN;
            RUN:     if (last_word)  next_state = DONE;
            DONE:    if (DoneReady)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        StartReady = 1'b0;
        DoneValid  = 1'b0;
        case (state)
            IDLE:    StartReady = 1'b1;
            DONE:    DoneValid  = 1'b1;
            default: ;
        endcase
    end

    // Subtraction is A + ~B + ~borrow, so B and the first carry are inverted once at accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx      <= '0;
            Sum      <= '0;
            CarryOUT <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (StartValid) begin
                        a_q     <= A;
                        b_q     <= Sub ? ~B : B;
                        carry_q <= CarryIN ^ Sub;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    Sum[idx*bits +: bits] <= add_sum;
                    carry_q               <= add_cout;
                    if (last_word) begin
                        idx      <= '0;
                        CarryOUT <= add_cout;
                        Overflow <= (a_word[bits-1] == b_word[bits-1]) &&
                                    (add_sum[bits-1] != a_word[bits-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_word_adder_controller.sv
// Directed bench for multi_word_adder_controller with WORDS=4 and hand-computed results.
module tb_multi_word_adder_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        StartValid = 1'b0;
    logic        StartReady;
    logic [63:0] A = '0;
    logic [63:0] B = '0;
    logic        CarryIN = 1'b0;
    logic        Sub = 1'b0;
    logic [63:0] Sum;
    logic        CarryOUT;
    logic        Overflow;
    logic        DoneValid;
    logic        DoneReady = 1'b0;

    int tests = 0;
    int fails = 0;
    int lat;

    multi_word_adder_controller #(.WORDS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .StartValid (StartValid),
        .StartReady (StartReady),
        .A          (A),
        .B          (B),
        .CarryIN    (CarryIN),
        .Sub        (Sub),
        .Sum        (Sum),
        .CarryOUT   (CarryOUT),
        .Overflow   (Overflow),
        .DoneValid  (DoneValid),
        .DoneReady  (DoneReady)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Accepts one request and returns the number of edges from accept to DoneValid (accept edge included).
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                          input logic sub, output int edges);
        @(negedge clk);
        A = a; B = b; CarryIN = cin; Sub = sub; StartValid = 1'b1;
        @(posedge clk); #1;
        StartValid = 1'b0;
        edges = 1;
        while (DoneValid !== 1'b1 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic handoff();
        @(negedge clk);
        DoneReady = 1'b1;
        @(posedge clk); #1;
        DoneReady = 1'b0;
        check("handoff_start_ready", {63'd0, StartReady}, 64'd1);
        check("handoff_done_valid", {63'd0, DoneValid}, 64'd0);
    endtask

    initial begin
        // Reset asserted between clock edges
        #2 reset = 1'b1;
        #1;
        check("rst_sum", Sum, 64'd0);
        check("rst_done_valid", {63'd0, DoneValid}, 64'd0);
        check("rst_carry", {63'd0, CarryOUT}, 64'd0);
        check("rst_ovf", {63'd0, Overflow}, 64'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_start_ready", {63'd0, StartReady}, 64'd1);

        // Cross-word carry
        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, lat);
        check("xw_latency", 64'(lat), 64'd5);
        check("xw_sum", Sum, 64'h0000_0000_0001_0000);
        check("xw_carry", {63'd0, CarryOUT}, 64'd0);
        check("xw_ovf", {63'd0, Overflow}, 64'd0);
        check("xw_start_ready", {63'd0, StartReady}, 64'd0);
        handoff();

        // Full ripple through all words
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, lat);
        check("rip_latency", 64'(lat), 64'd5);
        check("rip_sum", Sum, 64'h0);
        check("rip_carry", {63'd0, CarryOUT}, 64'd1);
        check("rip_ovf", {63'd0, Overflow}, 64'd0);
        handoff();

        // Subtract with borrow
        run_op(64'h5, 64'h7, 1'b0, 1'b1, lat);
        check("sub_sum", Sum, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_carry", {63'd0, CarryOUT}, 64'd0);
        check("sub_ovf", {63'd0, Overflow}, 64'd0);
        handoff();

        // Signed overflow
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat);
        check("ovf_sum", Sum, 64'h8000_0000_0000_0000);
        check("ovf_ovf", {63'd0, Overflow}, 64'd1);
        check("ovf_carry", {63'd0, CarryOUT}, 64'd0);
        handoff();

        // Subtract without borrow with borrow-in: 7 - 5 - 1 = 1, carry set
        run_op(64'h7, 64'h5, 1'b1, 1'b1, lat);
        check("subb_sum", Sum, 64'h1);
        check("subb_carry", {63'd0, CarryOUT}, 64'd1);
        check("subb_ovf", {63'd0, Overflow}, 64'd0);

        // Backpressure: result must hold while new requests are offered
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            StartValid = ~StartValid;
            A = 64'h1234_0000_0000_0000 + 64'(i);
            B = 64'h0000_5678_0000_0000;
            CarryIN = 1'b0; Sub = 1'b0;
            @(posedge clk); #1;
            check("bp_sum", Sum, 64'h1);
            check("bp_start_ready", {63'd0, StartReady}, 64'd0);
            check("bp_done_valid", {63'd0, DoneValid}, 64'd1);
        end
        @(negedge clk);
        StartValid = 1'b0;
        handoff();
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_no_second_op", {63'd0, DoneValid}, 64'd0);
        end

        // Reset during RUN discards the operation
        @(negedge clk);
        A = 64'h1111_2222_3333_4444; B = 64'h1; CarryIN = 1'b0; Sub = 1'b0;
        StartValid = 1'b1;
        @(posedge clk); #1;
        StartValid = 1'b0;
        @(posedge clk); #1;
        check("mid_in_run", {63'd0, StartReady}, 64'd0);
        #1 reset = 1'b1;
        #1;
        check("mid_sum", Sum, 64'd0);
        check("mid_done_valid", {63'd0, DoneValid}, 64'd0);
        check("mid_carry", {63'd0, CarryOUT}, 64'd0);
        check("mid_ovf", {63'd0, Overflow}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_start_ready", {63'd0, StartReady}, 64'd1);
        repeat (6) begin
            @(posedge clk); #1;
            check("mid_no_done", {63'd0, DoneValid}, 64'd0);
        end

        // Recovery after reset
        run_op(64'h0000_FFFF_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0, 1'b0, lat);
        check("rec_latency", 64'(lat), 64'd5);
        check("rec_sum", Sum, 64'h0001_0000_0000_0000);
        handoff();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multi_word_adder_controller.md
# multi_word_adder_controller

Sequences a multi-precision add/subtract of `WORDS` × 16-bit operands through one shared `sixteen_bit_adder` instance, one word per clock, least-significant word first. It registers the inter-word carry. Operands are accepted and results returned on valid/ready handshakes. It sits between an operand source (register file or test driver) and the result consumer, so wide arithmetic reuses the existing 16-bit adder.

## Interface
Parameters:
- `bits`, 16, width of one adder word; fixed by `sixteen_bit_adder`.
- `WORDS`, 4, number of words per operand; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `StartValid`  in  1  request carries valid operands.
- `StartReady`  out  1  controller can accept a request.
- `A`  in  WORDS*bits  operand A; word 0 = bits [bits-1:0].
- `B`  in  WORDS*bits  operand B.
- `CarryIN`  in  1  carry-in (add) or borrow-in (sub).
- `Sub`  in  1  0 = A+B+CarryIN; 1 = A−B−CarryIN.
- `Sum`  out  WORDS*bits  result.
- `CarryOUT`  out  1  raw carry out of the top word (for sub: 1 = no borrow).
- `Overflow`  out  1  two's-complement overflow of the full-width result.
- `DoneValid`  out  1  `Sum`, `CarryOUT` and `Overflow` are valid.
- `DoneReady`  in  1  consumer accepts the result.

## Operation
- FSM has three states: IDLE, RUN and DONE. Reset state is IDLE.
- **IDLE:**
  - `StartReady`=1.
  - On `StartValid`, latch:
    - `A` into `a_q`.
    - `B` into `b_q` (stored as `~B` if `Sub`).
    - The first-word carry into `carry_q` (`CarryIN` if add, `~CarryIN` if sub).
  - Set word index `idx`=0 and go to RUN.
- **RUN:**
  - The adder sees word `idx` of `a_q` and `b_q`, with `carry_q` on `CarryIN`.
  - Each edge:
    - Write the adder sum into `Sum` word `idx`.
    - Update `carry_q` from the adder's `CarryOUT`.
    - Increment `idx`.
  - On the edge that processes `idx`=WORDS−1, go to DONE.
  - At the same edge, load `CarryOUT` from the final carry and `Overflow` = (a_msb == b_msb) && (sum_msb != a_msb). The MSBs are those of `a_q`, effective `b_q` and the new sum.
- **DONE:**
  - `DoneValid`=1.
  - `Sum`, `CarryOUT` and `Overflow` hold stable.
  - On `DoneReady`, go to IDLE.
- `StartReady`=0 in RUN and DONE. `StartValid` in those states is ignored and does not queue.
- Inputs `A`, `B`, `CarryIN` and `Sub` are only sampled at the accept edge; later changes have no effect.
- Arithmetic is modulo 2^(WORDS*bits). `CarryOUT` is the raw adder carry and is not inverted for subtraction.
- `WORDS`=1: RUN lasts exactly one cycle.
- Reset at any time: return to IDLE with `Sum`=0, `CarryOUT`=0, `Overflow`=0, `DoneValid`=0, `StartReady`=1 (after reset deasserts), `idx`=0, `carry_q`=0. An in-flight operation is discarded.

## Timing
- Accept occurs at edge T when IDLE && `StartValid`.
- The RUN edges are T+1 … T+WORDS.
- `DoneValid` rises after edge T+WORDS; latency is WORDS+1 edges.
- Result handoff occurs at the first edge with `DoneValid` && `DoneReady`. `StartReady` is 1 from the next cycle.
- Minimum request-to-request spacing is WORDS+2 cycles.
- `Sum` words update progressively during RUN. Only the DONE-state value is architecturally defined.
- All outputs are registered, except that `StartReady` and `DoneValid` may be decoded directly from the state register.
- Combinational path per cycle is one `sixteen_bit_adder` plus operand/word muxing.

## Structure
- Shared package holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - `bits`=16.
- One sub-module: the existing `sixteen_bit_adder`, instantiated once with ports `.A`, `.B`, `.CarryIN`, `.CarryOUT`, `.Sum`.
- Word select uses an indexed part-select on `idx`. The counter width is $clog2(WORDS), minimum 1.

## Test plan
All values use WORDS=4.
- **Reset:** assert `reset` mid-cycle with no clock edge → `Sum`=0, `DoneValid`=0, `CarryOUT`=0, `Overflow`=0. After release, `StartReady`=1.
- **Cross-word carry:** `A`=0x0000_0000_0000_FFFF, `B`=0x1, `CarryIN`=0, `Sub`=0 → `Sum`=0x0000_0000_0001_0000, `CarryOUT`=0, `Overflow`=0. `DoneValid` asserts exactly 5 edges after accept.
- **Full ripple:** `A`=0xFFFF_FFFF_FFFF_FFFF, `B`=0, `CarryIN`=1, `Sub`=0 → `Sum`=0, `CarryOUT`=1, `Overflow`=0.
- **Subtract:** `A`=0x5, `B`=0x7, `CarryIN`=0, `Sub`=1 → `Sum`=0xFFFF_FFFF_FFFF_FFFE, `CarryOUT`=0, `Overflow`=0.
- **Signed overflow:** `A`=0x7FFF_FFFF_FFFF_FFFF, `B`=0x1, add → `Sum`=0x8000_0000_0000_0000, `Overflow`=1, `CarryOUT`=0.
- **Backpressure and reset mid-run:**
  - Hold `DoneReady`=0 for 5 cycles while pulsing `StartValid` with new operands → `Sum` stays stable, `StartReady`=0, and no second operation occurs.
  - Then assert `reset` during RUN of a new request → immediate IDLE, all outputs 0, and no `DoneValid`.
